// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit little-endian words from an 8-bit memory port.
// Optional direct-mapped I-cache is enabled by defining ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [1:0]  cnt_q;
  logic [23:0] buf_q;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic        valid_q;

  logic        hit;
  logic [31:0] hit_word;
  logic [31:0] fill_word;
  logic        tgt_unused;

  // Branch targets are forced word-aligned, so the low two bits are ignored.
  assign tgt_unused = ^branch_target_i[1:0];
  assign fill_word  = {mem_data_i, buf_q};

`ifdef ICACHE_EN
  localparam int IW = (ICACHE_LINES > 1) ? $clog2(ICACHE_LINES) : 1;
  localparam int TW = 30 - IW;

  logic [ICACHE_LINES-1:0] line_valid_q;
  logic [TW-1:0]           tag_mem [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];
  logic [IW-1:0]           idx;
  logic [TW-1:0]           tag;
  logic                    fill_en;

  assign idx      = pc_q[2+IW-1:2];
  assign tag      = pc_q[31:2+IW];
  assign hit      = (state_q == S_FETCH) && (cnt_q == 2'd0) &&
                    line_valid_q[idx] && (tag_mem[idx] == tag);
  assign hit_word = data_mem[idx];
  assign fill_en  = !rst && !branch_taken_i && (state_q == S_FETCH) && !hit &&
                    mem_ack_i && (cnt_q == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < ICACHE_LINES; gi++) begin : g_line_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          line_valid_q[gi] <= 1'b0;
        end else if (fill_en && (idx == IW'(gi))) begin
          line_valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag/data storage needs no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= fill_word;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (ICACHE_LINES == 0);
  assign hit        = 1'b0;
  assign hit_word   = 32'h0;
`endif

  assign mem_req_o  = !rst && (state_q == S_FETCH) && !hit;
  assign mem_addr_o = pc_q + {30'd0, cnt_q};
  assign pc_o       = pc_out_q;
  assign inst_o     = inst_q;
  assign valid_o    = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      cnt_q    <= 2'd0;
      buf_q    <= 24'h0;
      inst_q   <= 32'h0;
      pc_out_q <= 32'h0;
      valid_q  <= 1'b0;
    end else if (branch_taken_i) begin
      // Redirect abandons any partial word, including a byte acked this cycle.
      state_q <= S_FETCH;
      pc_q    <= {branch_target_i[31:2], 2'b00};
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (hit) begin
            inst_q   <= hit_word;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            state_q  <= S_VALID;
          end else if (mem_ack_i) begin
            if (cnt_q == 2'd3) begin
              inst_q   <= fill_word;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              cnt_q    <= 2'd0;
              state_q  <= S_VALID;
            end else begin
              case (cnt_q)
                2'd0:    buf_q[7:0]   <= mem_data_i;
                2'd1:    buf_q[15:8]  <= mem_data_i;
                default: buf_q[23:16] <= mem_data_i;
              endcase
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        S_VALID: begin
          if (!stall_i) begin
            valid_q <= 1'b0;
            pc_q    <= pc_q + 32'd4;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized self-checking bench for if_fetch against a word-level fetch model.
// Define ICACHE_EN for both files to exercise the cache path.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          LINES  = 64;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  if_fetch #(.RESET_PC(RST_PC), .ICACHE_LINES(LINES)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit verbose = 1'b1;

  // Model: which word is being fetched, how many bytes have arrived, what is presented.
  logic [31:0] m_pc;
  int          m_got;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pco;
  bit          c_valid [LINES];
  logic [31:0] c_pc    [LINES];

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0: mb = 8'h13;
      32'h1: mb = 8'h00;
      32'h2: mb = 8'h50;
      32'h3: mb = 8'h93;
      default: begin
        h  = a * 32'h9E37_79B1;
        mb = h[31:24] ^ h[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    word_at = {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
  endfunction

  function automatic int line_of(input logic [31:0] p);
    line_of = int'((p >> 2) % LINES);
  endfunction

  function automatic bit m_hit();
`ifdef ICACHE_EN
    m_hit = !m_valid && (m_got == 0) && c_valid[line_of(m_pc)] &&
            (c_pc[line_of(m_pc)] == m_pc);
`else
    m_hit = 1'b0;
`endif
  endfunction

  function automatic bit m_fetching();
    m_fetching = !m_valid && !m_hit();
  endfunction

  function automatic logic [31:0] m_addr();
    m_addr = m_pc + 32'(m_got);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit h;
    h = m_hit();
    if (rst) begin
      m_pc = RST_PC; m_got = 0; m_valid = 0; m_inst = 0; m_pco = 0;
      for (int i = 0; i < LINES; i++) c_valid[i] = 1'b0;
    end else if (branch_taken_i) begin
      m_pc = {branch_target_i[31:2], 2'b00}; m_got = 0; m_valid = 0;
    end else if (m_valid) begin
      if (!stall_i) begin
        if (verbose) $display("[TB] consumed pc=%h inst=%h", m_pco, m_inst);
        m_valid = 0;
        m_pc = m_pc + 32'd4;
      end
    end else if (h) begin
      m_valid = 1; m_inst = word_at(m_pc); m_pco = m_pc;
    end else if (mem_ack_i) begin
      m_got++;
      if (m_got == 4) begin
        m_got = 0; m_valid = 1; m_inst = word_at(m_pc); m_pco = m_pc;
        c_valid[line_of(m_pc)] = 1'b1;
        c_pc[line_of(m_pc)] = m_pc;
      end
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", {31'd0, mem_req_o}, {31'd0, !rst && m_fetching()});
      if (!rst && m_fetching()) chk("addr", mem_addr_o, m_addr());
      chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
      chk("pc_o", pc_o, m_pco);
      chk("inst_o", inst_o, m_inst);
    end
  end

  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit a);
    rst = r; stall_i = s; branch_taken_i = b; branch_target_i = t; mem_ack_i = a;
    mem_data_i = a ? mb(m_addr()) : 8'($urandom);
    @(posedge clk);
    model_update();
    @(negedge clk);
    #2;
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 1);
  endtask

  initial begin
    rst = 1; stall_i = 0; branch_taken_i = 0; branch_target_i = 0;
    mem_ack_i = 0; mem_data_i = 0;
    m_pc = 0; m_got = 0; m_valid = 0; m_inst = 0; m_pco = 0;
    for (int i = 0; i < LINES; i++) begin c_valid[i] = 0; c_pc[i] = 0; end
    #2;
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);

    // Back-to-back acks: addresses 0..3, word valid in cycle 5.
    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", mem_addr_o, 32'(i));
      step(0, 0, 0, 32'h0, 1);
    end
    chk("first_valid", {31'd0, valid_o}, 32'd1);
    chk("first_inst", inst_o, 32'h9350_0013);
    chk("first_pc", pc_o, 32'h0);

    // Stall holds the presented word with no requests.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0, 0);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
      chk("stall_inst", inst_o, 32'h9350_0013);
    end
    step(0, 0, 0, 32'h0, 0);
    chk("next_addr", mem_addr_o, 32'h4);

    // Branch with a same-cycle ack discards the byte.
    ack_n(2);
    chk("cnt2_addr", mem_addr_o, 32'h6);
    step(0, 0, 1, 32'h0000_1006, 1);
    chk("br_addr", mem_addr_o, 32'h0000_1004);
    ack_n(3);
    chk("br_partial", {31'd0, valid_o}, 32'd0);
    ack_n(1);
    chk("br_valid", {31'd0, valid_o}, 32'd1);
    chk("br_pc", pc_o, 32'h0000_1004);

    // Branch overrides stall while a word is presented.
    step(0, 1, 1, 32'h0000_0200, 0);
    chk("brst_valid", {31'd0, valid_o}, 32'd0);
    chk("brst_addr", mem_addr_o, 32'h0000_0200);

    // Sparse acks every third cycle.
    for (int i = 0; i < 12; i++) begin
      if (i == 11) chk("slow_partial", {31'd0, valid_o}, 32'd0);
      step(0, 0, 0, 32'h0, (i % 3) == 2);
    end
    chk("slow_valid", {31'd0, valid_o}, 32'd1);
    chk("slow_pc", pc_o, 32'h0000_0200);

    // Reset in the middle of a fetch.
    step(0, 0, 0, 32'h0, 0);
    ack_n(2);
    step(1, 0, 0, 32'h0, 0);
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    step(0, 0, 0, 32'h0, 0);
    chk("midrst_addr", mem_addr_o, RST_PC);

    // Address wrap at the top of memory.
    step(0, 0, 1, 32'hFFFF_FFFE, 0);
    chk("wrap_base", mem_addr_o, 32'hFFFF_FFFC);
    ack_n(3);
    chk("wrap_last", mem_addr_o, 32'hFFFF_FFFF);
    ack_n(1);
    step(0, 0, 0, 32'h0, 0);
    chk("wrap_pc", mem_addr_o, 32'h0);

`ifdef ICACHE_EN
    // pc 0 -> 4 -> branch back to 0 hits; an aliasing line evicts it.
    ack_n(4);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h0, 0);
    chk("hit_req", {31'd0, mem_req_o}, 32'd0);
    step(0, 1, 0, 32'h0, 0);
    chk("hit_valid", {31'd0, valid_o}, 32'd1);
    chk("hit_pc", pc_o, 32'h0);
    step(0, 0, 1, 32'(4 * LINES), 0);
    ack_n(4);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h0, 0);
    chk("evict_req", {31'd0, mem_req_o}, 32'd1);
`endif

    // Random traffic.
    verbose = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      bit r, s, b, a;
      logic [31:0] t;
      r = ($urandom_range(0, 299) == 0);
      b = ($urandom_range(0, 15) == 0);
      s = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'($urandom_range(0, 31) * 4);
        2:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 3) * LINES * 4);
      endcase
      a = m_fetching() && ($urandom_range(0, 9) < 6);
      step(r, s, b, t, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
